// File: rtl/maze_navigator.sv
// Depth-first maze solver: walks a 16x16 grid from START_LOC toward GOAL_LOC,
// keeping the current path on an external location stack.
module maze_navigator #(
  parameter logic [7:0] START_LOC = 8'h00,
  parameter logic [7:0] GOAL_LOC  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       maze_rd,
  output logic [7:0] maze_addr,
  input  logic       maze_data,
  output logic       stk_push,
  output logic       stk_pop,
  output logic [7:0] stk_din,
  input  logic [7:0] stk_dout,
  input  logic       stk_nonempty,
  output logic [7:0] cur_loc,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  typedef enum logic [3:0] {
    S_IDLE, S_DRAIN, S_EVAL, S_RD, S_WAIT, S_MOVE, S_POP, S_POPW, S_DONE, S_FAIL
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   cur_loc_q, cur_loc_d;
  logic [7:0]   cand_q, cand_d;
  logic [2:0]   dir_q, dir_d;
  logic [255:0] visited_q, visited_d;

  logic [3:0] row, col;
  logic [7:0] nbr;
  logic       nbr_in_grid;

  assign row = cur_loc_q[7:4];
  assign col = cur_loc_q[3:0];

  // Neighbour selected by dir: up, right, down, left; edges never wrap.
  always_comb begin
    nbr         = '0;
    nbr_in_grid = 1'b0;
    case (dir_q)
      3'd0: begin nbr = {row - 4'd1, col}; nbr_in_grid = (row != 4'd0);  end
      3'd1: begin nbr = {row, col + 4'd1}; nbr_in_grid = (col != 4'd15); end
      3'd2: begin nbr = {row + 4'd1, col}; nbr_in_grid = (row != 4'd15); end
      3'd3: begin nbr = {row, col - 4'd1}; nbr_in_grid = (col != 4'd0);  end
      default: begin nbr = '0; nbr_in_grid = 1'b0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cur_loc_d = cur_loc_q;
    cand_d    = cand_q;
    dir_d     = dir_q;
    visited_d = visited_q;
    maze_rd   = 1'b0;
    maze_addr = '0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_din   = '0;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          visited_d = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stk_pop = stk_nonempty;
        if (!stk_nonempty) begin
          cur_loc_d            = START_LOC;
          visited_d[START_LOC] = 1'b1;
          dir_d                = '0;
          state_d              = S_EVAL;
        end
      end
      S_EVAL: begin
        if (cur_loc_q == GOAL_LOC) begin
          state_d = S_DONE;
        end else if (dir_q == 3'd4) begin
          state_d = stk_nonempty ? S_POP : S_FAIL;
        end else if (!nbr_in_grid || visited_q[nbr]) begin
          dir_d = dir_q + 3'd1;
        end else begin
          cand_d  = nbr;
          state_d = S_RD;
        end
      end
      S_RD: begin
        maze_rd   = 1'b1;
        maze_addr = cand_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (maze_data) begin
          dir_d   = dir_q + 3'd1;
          state_d = S_EVAL;
        end else begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        stk_push          = 1'b1;
        stk_din           = cur_loc_q;
        cur_loc_d         = cand_q;
        visited_d[cand_q] = 1'b1;
        dir_d             = '0;
        state_d           = S_EVAL;
      end
      S_POP: begin
        stk_pop = 1'b1;
        state_d = S_POPW;
      end
      S_POPW: begin
        cur_loc_d = stk_dout;
        dir_d     = '0;
        state_d   = S_EVAL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_loc_q <= '0;
      cand_q    <= '0;
      dir_q     <= '0;
      visited_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_loc_q <= cur_loc_d;
      cand_q    <= cand_d;
      dir_q     <= dir_d;
      visited_q <= visited_d;
    end
  end

  assign cur_loc = cur_loc_q;
  assign busy    = !(state_q inside {S_IDLE, S_DONE, S_FAIL});
  assign done    = (state_q == S_DONE);
  assign fail    = (state_q == S_FAIL);

endmodule

// File: tb/tb_maze_navigator.sv
// Directed bench for maze_navigator with a behavioural maze memory and location stack.
module tb_maze_navigator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       maze_rd;
  logic [7:0] maze_addr;
  logic       maze_data;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic       stk_nonempty;
  logic [7:0] cur_loc;
  logic       busy;
  logic       done;
  logic       fail;

  // second instance with START_LOC == GOAL_LOC, stack always empty
  logic       start2;
  logic       maze_rd2, stk_push2, stk_pop2, busy2, done2, fail2;
  logic [7:0] maze_addr2, stk_din2, cur_loc2;
  logic       maze_data2 = 1'b0;
  logic [7:0] stk_dout2 = 8'h00;
  logic       stk_nonempty2 = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maze_navigator dut (
    .clk(clk), .rst(rst), .start(start),
    .maze_rd(maze_rd), .maze_addr(maze_addr), .maze_data(maze_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_nonempty(stk_nonempty),
    .cur_loc(cur_loc), .busy(busy), .done(done), .fail(fail)
  );

  maze_navigator #(.START_LOC(8'h37), .GOAL_LOC(8'h37)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .maze_rd(maze_rd2), .maze_addr(maze_addr2), .maze_data(maze_data2),
    .stk_push(stk_push2), .stk_pop(stk_pop2), .stk_din(stk_din2),
    .stk_dout(stk_dout2), .stk_nonempty(stk_nonempty2),
    .cur_loc(cur_loc2), .busy(busy2), .done(done2), .fail(fail2)
  );

  // maze memory: 1 = wall, data returned one cycle after the read strobe
  logic maze_mem [0:255];
  initial maze_data = 1'b0;
  always @(posedge clk) if (maze_rd) maze_data <= maze_mem[maze_addr];

  logic [7:0] stk_mem [0:255];
  int         depth;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      depth    <= 0;
      stk_dout <= 8'h00;
    end else if (stk_push) begin
      stk_mem[depth[7:0]] <= stk_din;
      depth <= depth + 1;
    end else if (stk_pop && depth != 0) begin
      stk_dout <= stk_mem[depth - 1];
      depth    <= depth - 1;
    end
  end
  assign stk_nonempty = (depth != 0);

  logic       clr_cnt = 1'b0;
  int         n_rd, n_push, n_pop, n_viol, pop_run, max_run, n2_act;
  logic [7:0] rd_log [0:7];
  always @(posedge clk) begin
    if (clr_cnt) begin
      n_rd <= 0; n_push <= 0; n_pop <= 0; n_viol <= 0;
      pop_run <= 0; max_run <= 0; n2_act <= 0;
    end else if (!rst) begin
      if (maze_rd) begin
        if (n_rd < 8) rd_log[n_rd[2:0]] <= maze_addr;
        n_rd <= n_rd + 1;
      end
      if (stk_push) n_push <= n_push + 1;
      if (stk_pop)  n_pop  <= n_pop + 1;
      if ((stk_push && stk_pop) || (stk_pop && !stk_nonempty)) n_viol <= n_viol + 1;
      pop_run <= stk_pop ? pop_run + 1 : 0;
      if (stk_pop && pop_run + 1 > max_run) max_run <= pop_run + 1;
      if (maze_rd2 || stk_push2 || stk_pop2) n2_act <= n2_act + 1;
    end
  end

  task automatic fill_open();
    for (int i = 0; i < 256; i++) maze_mem[i] = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    clr_cnt = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s timeout: busy=%0b after 5000 cycles, required 0", name, busy);
    end
  endtask

  task automatic check_open_result(input string name);
    logic [7:0] exp_path [0:29];
    int bad;
    for (int i = 0; i < 16; i++) exp_path[i] = 8'(i);
    for (int i = 1; i < 15; i++) exp_path[15 + i] = {4'(i), 4'hF};
    checks++;
    if ({done, fail, busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s flags: done/fail/busy=%b required 100", name, {done, fail, busy});
    end
    checks++;
    if (cur_loc !== 8'hFF) begin
      errors++;
      $display("FAIL %s cur_loc: got %h required ff", name, cur_loc);
    end
    checks++;
    if (n_rd !== 30 || n_push !== 30 || depth !== 30) begin
      errors++;
      $display("FAIL %s counts: reads=%0d pushes=%0d depth=%0d required 30/30/30",
               name, n_rd, n_push, depth);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) if (stk_mem[i] !== exp_path[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s path: %0d wrong stack entries (bottom=%h top=%h) required 0",
               name, bad, stk_mem[0], stk_mem[29]);
    end
    checks++;
    if (n_viol !== 0) begin
      errors++;
      $display("FAIL %s stack protocol: violations=%0d required 0", name, n_viol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    clr_cnt = 1'b1;
    fill_open();
    repeat (2) @(negedge clk);
    clr_cnt = 1'b0;
    checks++;
    if ({busy, done, fail, maze_rd, stk_push, stk_pop, maze_addr, stk_din, cur_loc, stk_nonempty} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b fail=%b rd=%b push=%b pop=%b addr=%h din=%h cur=%h ne=%b required all 0",
               busy, done, fail, maze_rd, stk_push, stk_pop, maze_addr, stk_din, cur_loc, stk_nonempty);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, fail} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: busy/done/fail=%b required 000", {busy, done, fail});
    end
  endtask

  task automatic test_all_open();
    fill_open();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL open_busy: busy=%b required 1", busy);
    end
    wait_idle("open");
    checks++;
    if (n_pop !== 0) begin
      errors++;
      $display("FAIL open_pops: got %0d required 0", n_pop);
    end
    check_open_result("open");
  endtask

  task automatic test_restart_drain();
    pulse_start();
    wait_idle("redrain");
    checks++;
    if (n_pop !== 30 || max_run !== 30) begin
      errors++;
      $display("FAIL redrain_pops: pops=%0d longest_run=%0d required 30/30", n_pop, max_run);
    end
    check_open_result("redrain");
  endtask

  task automatic test_all_walls();
    for (int i = 0; i < 256; i++) maze_mem[i] = 1'b1;
    maze_mem[0] = 1'b0;
    pulse_start();
    wait_idle("walls");
    checks++;
    if ({done, fail, stk_nonempty} !== 3'b010) begin
      errors++;
      $display("FAIL walls_flags: done/fail/nonempty=%b required 010", {done, fail, stk_nonempty});
    end
    checks++;
    if (n_rd !== 2 || rd_log[0] !== 8'h01 || rd_log[1] !== 8'h10 || n_push !== 0) begin
      errors++;
      $display("FAIL walls_reads: reads=%0d addr0=%h addr1=%h pushes=%0d required 2/01/10/0",
               n_rd, rd_log[0], rd_log[1], n_push);
    end
  endtask

  task automatic test_dead_end();
    for (int i = 0; i < 256; i++) maze_mem[i] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      maze_mem[i * 16] = 1'b0;
      maze_mem[240 + i] = 1'b0;
    end
    maze_mem[1] = 1'b0;
    pulse_start();
    wait_idle("deadend");
    checks++;
    if ({done, fail} !== 2'b10 || cur_loc !== 8'hFF) begin
      errors++;
      $display("FAIL deadend_done: done/fail=%b cur=%h required 10/ff", {done, fail}, cur_loc);
    end
    checks++;
    if (n_push !== 31 || n_pop !== 1 || depth !== 30 || n_viol !== 0) begin
      errors++;
      $display("FAIL deadend_counts: pushes=%0d pops=%0d depth=%0d viol=%0d required 31/1/30/0",
               n_push, n_pop, depth, n_viol);
    end
    checks++;
    if (stk_mem[0] !== 8'h00 || stk_mem[1] !== 8'h10 || stk_mem[15] !== 8'hF0 || stk_mem[29] !== 8'hFE) begin
      errors++;
      $display("FAIL deadend_path: [0]=%h [1]=%h [15]=%h [29]=%h required 00/10/f0/fe",
               stk_mem[0], stk_mem[1], stk_mem[15], stk_mem[29]);
    end
  endtask

  task automatic test_reset_mid_move();
    int i;
    fill_open();
    pulse_start();
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (stk_push && n_push == 4) break;
    end
    checks++;
    if (!stk_push) begin
      errors++;
      $display("FAIL midreset_reach_move: stk_push=%b required 1", stk_push);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, fail, maze_rd, stk_push, stk_pop, maze_addr, stk_din, cur_loc, stk_nonempty} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b rd=%b push=%b pop=%b addr=%h din=%h cur=%h ne=%b required all 0",
               busy, maze_rd, stk_push, stk_pop, maze_addr, stk_din, cur_loc, stk_nonempty);
    end
    @(negedge clk) rst = 1'b0;
    pulse_start();
    wait_idle("midreset");
    checks++;
    if (n_pop !== 0) begin
      errors++;
      $display("FAIL midreset_pops: got %0d required 0", n_pop);
    end
    check_open_result("midreset");
  endtask

  task automatic test_back_to_back_start();
    // first drain the prior result so the run under test has no pops
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    fill_open();
    pulse_start();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle("busystart");
    checks++;
    if (n_pop !== 0) begin
      errors++;
      $display("FAIL busystart_pops: got %0d required 0", n_pop);
    end
    check_open_result("busystart");
  endtask

  task automatic test_start_is_goal();
    @(negedge clk) begin clr_cnt = 1'b1; start2 = 1'b1; end
    @(negedge clk) begin clr_cnt = 1'b0; start2 = 1'b0; end
    repeat (6) @(negedge clk);
    checks++;
    if ({done2, fail2, busy2} !== 3'b100 || cur_loc2 !== 8'h37 || n2_act !== 0) begin
      errors++;
      $display("FAIL start_eq_goal: done/fail/busy=%b cur=%h strobes=%0d required 100/37/0",
               {done2, fail2, busy2}, cur_loc2, n2_act);
    end
  endtask

  initial begin
    test_reset();
    test_all_open();
    test_restart_drain();
    test_all_walls();
    test_dead_end();
    test_reset_mid_move();
    test_back_to_back_start();
    test_start_is_goal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
